axi_bridge_mp: RTL

Parametrised bridge between NPORT sram-like request ports and one AXI3 master interface. It generalises the fixed two-port (inst/data) bridge in three ways: a configurable port count, round-robin arbitration, and concurrent outstanding reads across ports (one per port), with per-port ID tagging. It sits between `cpu_core` (and any future cache/uncached ports) and the AXI interconnect inside `mycpu_top`.

---
 rtl/axi_bridge_pkg.sv | 34 +++
 rtl/axi_bridge_mp_rr_arbiter.sv | 42 ++++
 rtl/axi_bridge_mp.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_bridge_pkg.sv
// Shared constants, payload types and helpers for the multi-port sram-to-AXI3 bridge.
package axi_bridge_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STRB_W       = 4;
    localparam int unsigned LEN_W        = 4;
    localparam int unsigned SIZE_W       = 3;
    localparam int unsigned ID_W_DEFAULT = 4;

    localparam logic [1:0]        AXI_BURST_INCR = 2'b01;
    localparam logic [SIZE_W-1:0] AXI_SIZE_1B    = 3'b000;
    localparam logic [SIZE_W-1:0] AXI_SIZE_2B    = 3'b001;
    localparam logic [SIZE_W-1:0] AXI_SIZE_4B    = 3'b010;

    // One port's request payload as seen by the grant mux.
    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } port_req_t;

    // Byte-count code to AXI size; unused code 3 is treated as a word.
    function automatic logic [SIZE_W-1:0] size_to_axi(input logic [1:0] code);
        case (code)
            2'd0:    return AXI_SIZE_1B;
            2'd1:    return AXI_SIZE_2B;
            default: return AXI_SIZE_4B;
        endcase
    endfunction

endpackage

// File: rtl/axi_bridge_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer advances to the slot after the winner.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant_c
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;

    // Search order ptr, ptr+1, ... (mod N); first requester wins.
    always_comb begin
        grant_c = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && req[j] && (((32'(ptr) + off) % N) == j)) begin
                    found      = 1'b1;
                    grant_c[j] = 1'b1;
                    ptr_nxt    = PW'((j + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/axi_bridge_mp.sv
// Bridge from NPORT sram-like ports to one AXI3 master: one AR register, one
// write slot, one outstanding transaction per port tagged with AXI ID = port.
module axi_bridge_mp
    import axi_bridge_pkg::*;
#(
    parameter int unsigned NPORT = 2,
    parameter int unsigned ID_W  = ID_W_DEFAULT
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [NPORT-1:0]        req,
    input  logic [NPORT-1:0]        wr,
    input  logic [2*NPORT-1:0]      size,
    input  logic [4*NPORT-1:0]      wstrb,
    input  logic [32*NPORT-1:0]     addr,
    input  logic [32*NPORT-1:0]     wdata,
    output logic [NPORT-1:0]        addr_ok,
    output logic [NPORT-1:0]        data_ok,
    output logic [DATA_W-1:0]       rdata,
    output logic [ID_W-1:0]         arid,
    output logic [ADDR_W-1:0]       araddr,
    output logic [LEN_W-1:0]        arlen,
    output logic [SIZE_W-1:0]       arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_W-1:0]         rid,
    input  logic [DATA_W-1:0]       axi_rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ID_W-1:0]         awid,
    output logic [ADDR_W-1:0]       awaddr,
    output logic [LEN_W-1:0]        awlen,
    output logic [SIZE_W-1:0]       awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_W-1:0]         wid,
    output logic [DATA_W-1:0]       axi_wdata,
    output logic [STRB_W-1:0]       axi_wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_W-1:0]         bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    logic [NPORT-1:0] busy;
    logic [NPORT-1:0] hazard;
    logic [NPORT-1:0] rd_elig;
    logic [NPORT-1:0] wr_elig;
    logic [NPORT-1:0] grant;
    logic [NPORT-1:0] rd_hit;
    logic [NPORT-1:0] wr_hit;
    logic             wslot_full;
    logic             g_any;
    port_req_t        g_req;
    logic [ID_W-1:0]  g_id;
    logic             unused_resp;

    assign arlen   = '0;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign awlen   = '0;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign wlast   = 1'b1;
    assign rready  = 1'b1;
    assign bready  = 1'b1;

    assign unused_resp = ^{rresp, rlast, bresp};

    // Per-port eligibility; a read to the outstanding write's word waits for bvalid.
    always_comb begin
        hazard  = '0;
        rd_elig = '0;
        wr_elig = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            hazard[p]  = wslot_full && (addr[32*p+2 +: 30] == awaddr[ADDR_W-1:2]);
            rd_elig[p] = req[p] && !wr[p] && !busy[p] && !arvalid && !hazard[p];
            wr_elig[p] = req[p] &&  wr[p] && !busy[p] && !wslot_full;
        end
    end

    rr_arbiter #(
        .N (NPORT)
    ) u_arb (
        .clk     (aclk),
        .rst     (areset),
        .req     (rd_elig | wr_elig),
        .grant_c (grant)
    );

    assign addr_ok = grant;
    assign g_any   = |grant;

    // Payload of the granted port.
    always_comb begin
        g_req = '0;
        g_id  = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (grant[p]) begin
                g_req.wr   = wr[p];
                g_req.size = size[2*p +: 2];
                g_req.addr = addr[32*p +: 32];
                g_req.data = wdata[32*p +: 32];
                g_req.strb = wstrb[4*p +: 4];
                g_id       = ID_W'(p);
            end
        end
    end

    // Response demux; IDs that match no busy port are dropped.
    always_comb begin
        rd_hit = '0;
        wr_hit = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            rd_hit[p] = rvalid && (rid == ID_W'(p)) && busy[p];
            wr_hit[p] = bvalid && (bid == ID_W'(p)) && busy[p];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            busy    <= '0;
            data_ok <= '0;
            rdata   <= '0;
        end else begin
            busy    <= (busy | grant) & ~(rd_hit | wr_hit);
            data_ok <= rd_hit | wr_hit;
            if (|rd_hit) begin
                rdata <= axi_rdata;
            end
        end
    end

    // AR holding register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arvalid <= 1'b0;
            araddr  <= '0;
            arsize  <= '0;
            arid    <= '0;
        end else if (g_any && !g_req.wr) begin
            arvalid <= 1'b1;
            araddr  <= g_req.addr;
            arsize  <= size_to_axi(g_req.size);
            arid    <= g_id;
        end else if (arvalid && arready) begin
            arvalid <= 1'b0;
        end
    end

    // Write slot: AW and W drop independently, slot frees on bvalid.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wslot_full <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            awaddr     <= '0;
            awsize     <= '0;
            awid       <= '0;
            wid        <= '0;
            axi_wdata  <= '0;
            axi_wstrb  <= '0;
        end else if (g_any && g_req.wr) begin
            wslot_full <= 1'b1;
            awvalid    <= 1'b1;
            wvalid     <= 1'b1;
            awaddr     <= g_req.addr;
            awsize     <= size_to_axi(g_req.size);
            awid       <= g_id;
            wid        <= g_id;
            axi_wdata  <= g_req.data;
            axi_wstrb  <= g_req.strb;
        end else begin
            if (awvalid && awready) begin
                awvalid <= 1'b0;
            end
            if (wvalid && wready) begin
                wvalid <= 1'b0;
            end
            if (bvalid && wslot_full) begin
                wslot_full <= 1'b0;
            end
        end
    end

endmodule
